// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer
// Optional CSR zimm decode (fmt Z) enabled by defining IMMGEN_ZICSR_EN.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] d_imm;
    logic [2:0]      d_fmt;
    logic            d_ill;
    entry_t          dec, m_q, k_q;
    logic            m_valid, k_valid, ready_q;
    logic            accept, drain;

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMMGEN_ZICSR_EN
    logic [XLEN-1:0] imm_z;
    assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};
`endif

    always_comb begin
        d_imm = '0;
        d_fmt = FMT_NONE;
        d_ill = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin d_fmt = FMT_I; d_imm = imm_i; end
            7'b0100011: begin d_fmt = FMT_S; d_imm = imm_s; end
            7'b1100011: begin d_fmt = FMT_B; d_imm = imm_b; end
            7'b0110111, 7'b0010111: begin d_fmt = FMT_U; d_imm = imm_u; end
            7'b1101111: begin d_fmt = FMT_J; d_imm = imm_j; end
            7'b0110011, 7'b0001111: d_ill = 1'b0;
            7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
                // csrr*i forms carry a 5-bit zero-extended immediate in rs1
                if (in_instr[14]) begin
                    d_fmt = 3'd6;
                    d_imm = imm_z;
                end
`endif
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    d_fmt = FMT_I;
                    d_imm = imm_i;
                end else begin
                    d_ill = 1'b1;
                end
            end
            7'b0111011: d_ill = (XLEN != 64);
            default:    d_ill = 1'b1;
        endcase
    end

    assign dec.imm     = d_imm;
    assign dec.target  = in_pc + d_imm;
    assign dec.fmt     = d_fmt;
    assign dec.illegal = d_ill;

    assign accept = in_valid && ready_q;
    assign drain  = m_valid && out_ready;

    // ready_q mirrors !k_valid but is its own flop so in_ready has no logic after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            k_q     <= '0;
            m_valid <= 1'b0;
            k_valid <= 1'b0;
            ready_q <= 1'b1;
        end else if (drain && k_valid) begin
            m_q     <= k_q;
            k_valid <= 1'b0;
            ready_q <= 1'b1;
        end else if (accept && (!m_valid || drain)) begin
            m_q     <= dec;
            m_valid <= 1'b1;
        end else if (accept) begin
            k_q     <= dec;
            k_valid <= 1'b1;
            ready_q <= 1'b0;
        end else if (drain) begin
            m_valid <= 1'b0;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = m_valid;
    assign out_imm     = m_q.imm;
    assign out_fmt     = m_q.fmt;
    assign out_target  = m_q.target;
    assign out_illegal = m_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v32 = 1'b0, v64 = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
    logic [31:0] imm32, tgt32;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt32, fmt64;
    int          checks = 0, errors = 0;
    bit          rnd_done = 0;
    exp_t        q32[$], q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_instr(instr),
        .in_pc(pc[31:0]), .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_target(tgt32), .out_illegal(ill32));

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_instr(instr),
        .in_pc(pc), .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_target(tgt64), .out_illegal(ill64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] p, input bit x64);
        exp_t e;
        e.imm = 0; e.fmt = 0; e.ill = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin e.fmt = 1; e.imm = 64'($signed(ins[31:20])); end
            7'h23: begin e.fmt = 2; e.imm = 64'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin e.fmt = 3; e.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
            7'h37, 7'h17: begin e.fmt = 4; e.imm = 64'($signed({ins[31:12], 12'h000})); end
            7'h6F: begin e.fmt = 5; e.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            7'h33, 7'h0F: e.ill = 0;
            7'h73: begin
`ifdef IMMGEN_ZICSR_EN
                if (ins[14]) begin e.fmt = 6; e.imm = {59'd0, ins[19:15]}; end
`endif
            end
            7'h1B: if (x64) begin e.fmt = 1; e.imm = 64'($signed(ins[31:20])); end else e.ill = 1;
            7'h3B: e.ill = !x64;
            default: e.ill = 1;
        endcase
        e.tgt = p + e.imm;
        if (!x64) begin
            e.imm = e.imm & 64'hFFFF_FFFF;
            e.tgt = e.tgt & 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            chk("rst_out_valid32", {63'd0, ov32}, 0);
            chk("rst_in_ready32", {63'd0, rdy32}, 1);
            chk("rst_imm32", {32'd0, imm32}, 0);
            chk("rst_fmt32", {61'd0, fmt32}, 0);
            chk("rst_tgt32", {32'd0, tgt32}, 0);
            chk("rst_ill32", {63'd0, ill32}, 0);
        end else begin
            chk("in_ready32", {63'd0, rdy32}, {63'd0, q32.size() < 2});
            chk("out_valid32", {63'd0, ov32}, {63'd0, q32.size() > 0});
            if (ov32 && q32.size() > 0) begin
                chk("imm32", {32'd0, imm32}, q32[0].imm);
                chk("fmt32", {61'd0, fmt32}, {61'd0, q32[0].fmt});
                chk("tgt32", {32'd0, tgt32}, q32[0].tgt);
                chk("ill32", {63'd0, ill32}, {63'd0, q32[0].ill});
                if (out_ready) void'(q32.pop_front());
            end
            if (v32 && rdy32) q32.push_back(ref_dec(instr, pc, 0));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q64.delete();
            chk("rst_out_valid64", {63'd0, ov64}, 0);
            chk("rst_in_ready64", {63'd0, rdy64}, 1);
            chk("rst_imm64", imm64, 0);
            chk("rst_fmt64", {61'd0, fmt64}, 0);
            chk("rst_tgt64", tgt64, 0);
            chk("rst_ill64", {63'd0, ill64}, 0);
        end else begin
            chk("in_ready64", {63'd0, rdy64}, {63'd0, q64.size() < 2});
            chk("out_valid64", {63'd0, ov64}, {63'd0, q64.size() > 0});
            if (ov64 && q64.size() > 0) begin
                chk("imm64", imm64, q64[0].imm);
                chk("fmt64", {61'd0, fmt64}, {61'd0, q64[0].fmt});
                chk("tgt64", tgt64, q64[0].tgt);
                chk("ill64", {63'd0, ill64}, {63'd0, q64[0].ill});
                if (out_ready) void'(q64.pop_front());
            end
            if (v64 && rdy64) q64.push_back(ref_dec(instr, pc, 1));
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] p);
        int  n = 0;
        bit  a32, a64;
        instr = ins; pc = p; v32 = 1; v64 = 1;
        while ((v32 || v64) && n < 50) begin
            @(negedge clk);
            a32 = v32 && rdy32;
            a64 = v64 && rdy64;
            @(posedge clk); #1;
            if (a32) v32 = 0;
            if (a64) v64 = 0;
            n++;
        end
        chk("send_accepted", {63'd0, v32 || v64}, 0);
        v32 = 0; v64 = 0;
    endtask

    task automatic direct(input logic [31:0] ins, input logic [63:0] p, input logic [63:0] eimm,
                          input logic [63:0] etgt, input logic [2:0] efmt32, input logic eill32,
                          input logic [2:0] efmt64, input logic eill64);
        send(ins, p);
        @(negedge clk);
        chk("dir_imm32", {32'd0, imm32}, eimm & 64'hFFFF_FFFF);
        chk("dir_tgt32", {32'd0, tgt32}, etgt & 64'hFFFF_FFFF);
        chk("dir_fmt32", {61'd0, fmt32}, {61'd0, efmt32});
        chk("dir_ill32", {63'd0, ill32}, {63'd0, eill32});
        if (!eill32 || efmt64 != 0 || eill64) begin
            chk("dir_imm64", imm64, (efmt64 == 0) ? 64'd0 : eimm);
            chk("dir_fmt64", {61'd0, fmt64}, {61'd0, efmt64});
            chk("dir_ill64", {63'd0, ill64}, {63'd0, eill64});
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops[16] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                                 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h00, 7'h7F, 7'h2B};
        logic [31:0] r = $urandom;
        logic [6:0]  op = ops[$urandom_range(15)];
        return {r[31:7], op};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1; out_ready = 1;
        direct(32'hFFF00093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 1, 0, 1, 0);
        direct(32'hFE000EE3, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC, 3, 0, 3, 0);
        direct(32'h0010006F, 64'h1000, 64'h800, 64'h1800, 5, 0, 5, 0);
        direct(32'h800000B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 4, 0, 4, 0);
        direct(32'h0000001B, 64'h40, 64'h0, 64'h40, 0, 1, 1, 0);
`ifdef IMMGEN_ZICSR_EN
        direct(32'h3002D073, 64'h80, 64'h5, 64'h85, 6, 0, 6, 0);
`else
        direct(32'h3002D073, 64'h80, 64'h0, 64'h80, 0, 0, 0, 0);
`endif
        // backpressure: three back-to-back beats against a stalled consumer
        out_ready = 0;
        fork
            begin
                send(32'h00A00113, 64'h300);
                send(32'h00B12023, 64'h304);
                send(32'hFE000AE3, 64'h308);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        // reset while both registers are occupied
        #1 out_ready = 0;
        send(32'h12345037, 64'h400);
        send(32'h7FF00513, 64'h404);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1; out_ready = 1;
        send(32'h0040006F, 64'h500);
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 300; i++) send(rnd_instr(), {$urandom, $urandom});
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1 out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        out_ready = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain32", q32.size(), 0);
        chk("drain64", q64.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Each accepted 32-bit instruction is decoded into its format class, a sign-extended XLEN-bit immediate, a PC-relative target (pc + imm) and an illegal-opcode flag. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so both `in_ready` and all outputs come straight from flops. It sits between instruction fetch and the register-read/execute boundary.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64 only. Immediates and the target are XLEN bits wide.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an instruction is offered.
- `in_ready` output 1: the block can accept; driven directly by a flop.
- `in_instr` input 32: instruction word.
- `in_pc` input XLEN: PC of `in_instr`.
- `out_valid` output 1: the output bundle is valid.
- `out_ready` input 1: the consumer accepts.
- `out_imm` output XLEN: sign-extended immediate.
- `out_fmt` output 3: format class. 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved.
- `out_target` output XLEN: `in_pc + out_imm`, modulo 2^XLEN.
- `out_illegal` output 1: the opcode is unsupported.

## Operation
- **Decode on `in_instr[6:0]`**:
  - I format: load 0000011, op-imm 0010011, jalr 1100111. Immediate is sext(instr[31:20]).
  - S format: store 0100011. Immediate is sext({instr[31:25], instr[11:7]}).
  - B format: branch 1100011. Immediate is sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U format: lui 0110111, auipc 0010111. Immediate is sext({instr[31:12], 12'b0}).
  - J format: jal 1101111. Immediate is sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - NONE, legal, immediate 0: op 0110011, fence 0001111, system 1110011 (except Z, see Configuration).
  - `XLEN`=64 only: op-imm-32 0011011 is I format; op-32 0111011 is NONE.
  - Any other opcode, including op-imm-32/op-32 when `XLEN`=32: fmt NONE, immediate 0, `out_illegal`=1.
- **Sign extension** is always from instr[31] to the full XLEN, including U format on XLEN=64.
- **Target** is always `pc + imm`, including for jalr. The real jalr target is formed in execute.
- **Pipeline storage**: a main register (M) and a skid register (K), each with its own valid bit.
  - Outputs always present M.
  - `in_ready` = !K.valid, registered.
- **Per-cycle update rules**:
  - Input handshake (`in_valid && in_ready`) while M is empty, or while M drains this cycle (`out_ready`): the decoded result loads M.
  - Input handshake while M is full and not draining: the result loads K, and `in_ready` falls next cycle.
  - M drains while K is full: K moves to M, K empties, and `in_ready` rises next cycle.
  - M drains with no input handshake and K empty: `out_valid` falls next cycle.
- **Ordering**: results are never reordered, dropped or duplicated.
- **Output stability**: while `out_valid && !out_ready`, all output fields are held stable.
- **Reset** (async assert, any cycle, including mid-stall): `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_fmt`=0, `out_target`=0, `out_illegal`=0. Both valid bits clear and in-flight entries are discarded.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- `in_ready` drops one cycle after the first stall cycle in which an input is accepted. The skid register absorbs that one extra beat.
- Simultaneous accept and drain with K full cannot occur, because `in_ready`=0 whenever K is full.
- Decode is combinational between `in_instr` and the M/K input muxes. The adder is XLEN wide on the same path, so there is no output combinational path.

## Configuration
- `IMMGEN_ZICSR_EN`:
  - Defined: system opcode 1110011 with funct3[2]=1 (csrrwi/csrrsi/csrrci) gives fmt Z (6) and immediate zext(instr[19:15]).
  - Not defined: those instructions give fmt NONE and immediate 0.
  - All other decode is identical in both builds.

## Test plan
- XLEN=32, `0xFFF00093` (addi x1,x0,-1), pc 0x100, `out_ready`=1 -> next cycle `out_imm`=0xFFFFFFFF, fmt 1, target 0xFF, illegal 0.
- `0xFE000EE3` (beq -4), pc 0x2000 -> imm 0xFFFFFFFC, fmt 3, target 0x1FFC. Then `0x0010006F` (jal +2048), pc 0x1000 -> imm 0x800, fmt 5, target 0x1800.
- XLEN=64, `0x800000B7` (lui) -> imm 0xFFFFFFFF80000000, fmt 4. Then `0x0000001B` -> fmt 1, illegal 0. The same `0x0000001B` at XLEN=32 -> illegal 1, fmt 0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 and stream 3 back-to-back valid instructions.
  - Required: exactly 2 accepted, `in_ready`=0 from the cycle after the second accept, M output held constant.
  - Release `out_ready`: all 3 emerge in order, with no gaps once streaming resumes.
- Reset while M and K are both full -> outputs and flags at their reset values immediately. The first post-reset instruction emerges with no stale data.
- `0x3002D073` (csrrwi):
  - With `IMMGEN_ZICSR_EN`: imm 5, fmt 6.
  - Without it: imm 0, fmt 0.
  - Both builds: illegal 0.
